// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter sharing one UART transmit datapath among N_REQ byte
// producers. A winner's byte is captured into tx_data, tx_load/gnt pulse for
// one cycle, and ownership is held until the transmitter ends the frame.
//
// Optional feature macro: UART_TX_ARB_BURST_EN
//   When defined, the current owner may keep the transmitter for up to
//   BURST_MAX back-to-back frames (SEND -> LOAD without passing IDLE).
//   When undefined, every frame returns through IDLE and priority rotates.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no frame owned; arbitrate among pending requests
// LOAD   | one cycle: gnt[owner] and tx_load asserted, byte handed over
// WAIT   | byte loaded, waiting for transmitter to report busy
// SEND   | frame on the wire, waiting for tx_done (or busy falling)

module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4,
    localparam int IDX_W    = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          gnt,
    output logic                      tx_load,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    input  logic                      tx_done,
    output logic [IDX_W-1:0]          owner,
    output logic                      active
);

    if (N_REQ < 2 || N_REQ > 8 || BURST_MAX < 1) begin : g_cfg_check
        $error("uart_tx_arbiter: N_REQ must be 2..8 and BURST_MAX >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_SEND = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   ptr_d;
    logic [IDX_W-1:0]   owner_d;
    logic [DATA_W-1:0]  tx_data_d;
    logic [N_REQ-1:0]   gnt_d;
    logic               tx_load_d;
    logic               active_d;

    logic               found;
    logic [IDX_W-1:0]   sel;
    logic [DATA_W-1:0]  slot [N_REQ];

`ifdef UART_TX_ARB_BURST_EN
    localparam int BC_W = $clog2(BURST_MAX) + 1;
    logic [BC_W-1:0]    burst_q;
    logic [BC_W-1:0]    burst_d;
`endif

    // Unpack the flat byte bus so a requester's byte can be picked by index.
    for (genvar g = 0; g < N_REQ; g++) begin : g_slot
        assign slot[g] = req_data[g*DATA_W +: DATA_W];
    end

    // Round-robin search: first pending request after the last winner.
    always_comb begin
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IDX_W'((int'(ptr_q) + i) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Next-state and next-output logic; outputs are registered from state_d.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner;
        tx_data_d = tx_data;
`ifdef UART_TX_ARB_BURST_EN
        burst_d   = burst_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d   = S_LOAD;
                    owner_d   = sel;
                    tx_data_d = slot[sel];
                    ptr_d     = sel;
                end
            end
            S_LOAD: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A frame that finishes before busy was ever seen still ends here.
                if (tx_done) begin
                    state_d = S_IDLE;
                end else if (tx_busy) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_done) begin
`ifdef UART_TX_ARB_BURST_EN
                    // Keep the same owner without re-arbitrating; ptr stays put
                    // so the rotation resumes after this owner once the burst ends.
                    if (req[owner] && (int'(burst_q) < BURST_MAX - 1)) begin
                        state_d   = S_LOAD;
                        tx_data_d = slot[owner];
                        burst_d   = burst_q + 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
`else
                    state_d = S_IDLE;
`endif
                end else if (!tx_busy) begin
                    // Transmitter dropped busy without a done pulse: frame over.
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef UART_TX_ARB_BURST_EN
        if (state_d == S_IDLE) begin
            burst_d = '0;
        end
`endif

        gnt_d          = '0;
        gnt_d[owner_d] = (state_d == S_LOAD);
        tx_load_d      = (state_d == S_LOAD);
        active_d       = (state_d != S_IDLE);
    end

    // State, priority pointer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= IDX_W'(N_REQ - 1);
            owner   <= '0;
            tx_data <= '0;
            gnt     <= '0;
            tx_load <= 1'b0;
            active  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner   <= owner_d;
            tx_data <= tx_data_d;
            gnt     <= gnt_d;
            tx_load <= tx_load_d;
            active  <= active_d;
        end
    end

`ifdef UART_TX_ARB_BURST_EN
    // Consecutive-grant counter for the current owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus pushes expected grants,
// a negedge monitor pops and compares whenever the DUT loads a byte.
module tb_uart_tx_arbiter;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 8;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [N_REQ-1:0]        req = '0;
    logic [N_REQ*DATA_W-1:0] req_data = 32'h4433_2211;
    logic [N_REQ-1:0]        gnt;
    logic                    tx_load;
    logic [DATA_W-1:0]       tx_data;
    logic                    tx_busy;
    logic                    tx_done;
    logic [1:0]              owner;
    logic                    active;

    uart_tx_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .BURST_MAX(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .tx_load  (tx_load),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .owner    (owner),
        .active   (active)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp   = 0;
    int   n_fail  = 0;
    int   n_gnt   = 0;
    int   xm_mode = 1;
    int   xm_cnt  = -1;
    logic prev_load = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    task automatic push(input int idx, input logic [7:0] data);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic wait_grants(input int n, input string name);
        int target;
        int k;
        target = n_gnt + n;
        k = 0;
        while (n_gnt < target && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (n_gnt < target) timeout(name);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (active && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (active) timeout(name);
        @(negedge clk);
    endtask

    // active must be low right after the edge that saw tx_done
    task automatic done_then_idle(input string name);
        int k;
        k = 0;
        do begin
            @(posedge clk);
            k++;
        end while (!tx_done && k < 100);
        if (!tx_done) timeout(name);
        else begin
            #1 chk(name, active, 0);
        end
        @(negedge clk);
    endtask

    // Transmitter model: mode 1 normal frame, mode 2 done without busy,
    // mode 3 busy falls without done.
    initial begin
        tx_busy = 1'b0;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                xm_cnt = -1; tx_busy = 1'b0; tx_done = 1'b0;
            end else if (tx_load) begin
                xm_cnt = 0; tx_busy = 1'b0; tx_done = 1'b0;
            end else if (xm_cnt >= 0) begin
                xm_cnt++;
                case (xm_mode)
                    1: begin
                        if (xm_cnt == 2)  tx_busy = 1'b1;
                        if (xm_cnt == 12) tx_done = 1'b1;
                        if (xm_cnt == 13) begin tx_busy = 1'b0; tx_done = 1'b0; xm_cnt = -1; end
                    end
                    2: begin
                        if (xm_cnt == 3) tx_done = 1'b1;
                        if (xm_cnt == 4) begin tx_done = 1'b0; xm_cnt = -1; end
                    end
                    default: begin
                        if (xm_cnt == 2) tx_busy = 1'b1;
                        if (xm_cnt == 5) begin tx_busy = 1'b0; xm_cnt = -1; end
                    end
                endcase
            end
        end
    end

    // Monitor: every byte handed to the transmitter is checked against the queue.
    always @(negedge clk) begin
        exp_t       e;
        logic [3:0] eg;
        if (!rst) begin
            if (tx_load || gnt != 4'b0) begin
                n_gnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_grant: gnt=%b tx_load=%b owner=%0d", gnt, tx_load, owner);
                end else begin
                    e  = exp_q.pop_front();
                    eg = 4'b0001 << e.idx;
                    chk("gnt", gnt, eg);
                    chk("tx_load", tx_load, 1);
                    chk("tx_data", tx_data, e.data);
                    chk("owner", owner, e.idx);
                    chk("grant_single_cycle", prev_load, 0);
                end
            end
            prev_load = tx_load;
        end else begin
            prev_load = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // Reset with all requests pending
        rst = 1'b1;
        req = 4'b1111;
        xm_mode = 1;
        repeat (3) @(negedge clk);
        chk("rst_active", active, 0);
        chk("rst_tx_load", tx_load, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_owner", owner, 0);

        // Fairness with all requesting
`ifdef UART_TX_ARB_BURST_EN
        push(0, 8'h11); push(0, 8'h11); push(0, 8'h11); push(0, 8'h11); push(1, 8'h22);
`else
        push(0, 8'h11); push(1, 8'h22); push(2, 8'h33); push(3, 8'h44); push(0, 8'h11);
`endif
        rst = 1'b0;
        wait_grants(5, "fair_grants");
        req = 4'b0000;
        wait_idle("fair_idle");

        // Single requester 2 with byte 0xA5
        req_data[23:16] = 8'hA5;
        push(2, 8'hA5);
        req = 4'b0100;
        @(negedge clk);
        chk("a5_load_next_cycle", tx_load, 1);
        req = 4'b0000;
        done_then_idle("a5_active_drop");

        // Reset asserted while in SEND
        push(0, 8'h11);
        req = 4'b0001;
        wait_grants(1, "rst_send_grant");
        req = 4'b0000;
        k = 0;
        do begin
            @(posedge clk);
            k++;
        end while (!tx_busy && k < 50);
        if (!tx_busy) timeout("rst_send_busy");
        @(posedge clk);
        #3;
        chk("send_active", active, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_active", active, 0);
        chk("async_rst_tx_data", tx_data, 0);
        chk("async_rst_gnt", gnt, 0);
        chk("async_rst_tx_load", tx_load, 0);
        chk("async_rst_owner", owner, 0);
        req = 4'b1111;
`ifdef UART_TX_ARB_BURST_EN
        push(0, 8'h11); push(0, 8'h11);
`else
        push(0, 8'h11); push(1, 8'h22);
`endif
        @(negedge clk);
        rst = 1'b0;
        wait_grants(2, "post_rst_grants");
        req = 4'b0000;
        wait_idle("post_rst_idle");

        // tx_done while still in WAIT
        xm_mode = 2;
        push(1, 8'h22);
        req = 4'b0010;
        wait_grants(1, "wait_done_grant");
        req = 4'b0000;
        done_then_idle("wait_done_idle");
        xm_mode = 1;
`ifdef UART_TX_ARB_BURST_EN
        push(3, 8'h44); push(3, 8'h44);
`else
        push(3, 8'h44); push(1, 8'h22);
`endif
        req = 4'b1010;
        wait_grants(2, "after_wait_done");
        req = 4'b0000;
        wait_idle("after_wait_done_idle");

        // tx_busy falls without tx_done
        xm_mode = 3;
        push(0, 8'h11);
        req = 4'b0001;
        wait_grants(1, "busy_drop_grant");
        req = 4'b0000;
        k = 0;
        do begin
            @(posedge clk);
            k++;
        end while (!tx_busy && k < 50);
        k = 0;
        do begin
            @(posedge clk);
            k++;
        end while (tx_busy && k < 50);
        if (tx_busy) timeout("busy_drop");
        else begin
            #1 chk("busy_drop_idle", active, 0);
        end
        @(negedge clk);
        xm_mode = 1;

`ifdef UART_TX_ARB_BURST_EN
        // Burst: requester 0 gets 4 grants, then requester 1 gets 4
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) push(0, 8'h11);
        for (int i = 0; i < 4; i++) push(1, 8'h22);
        req = 4'b0011;
        wait_grants(8, "burst_grants");
        req = 4'b0000;
        wait_idle("burst_idle");
`endif

        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmit datapath (data register, shift register, transmit control FSM) among `N_REQ` byte producers. It selects a requester, captures its byte, pulses the transmitter's load strobe, and then holds ownership until the transmitter reports frame completion. It sits between the client blocks (console, debug port, status reporter) and the UART transmit path.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `DATA_W`, 8, byte width
- `BURST_MAX`, 4, max consecutive bytes per grant; used only when the burst feature is compiled in
- `clk`  input  1  system clock, rising edge
- `rst`  input  1  asynchronous, active-high reset
- `req`  input  N_REQ  per-requester byte-pending flag; held high until `gnt`
- `req_data`  input  N_REQ*DATA_W  requester i's byte at bits [i*DATA_W +: DATA_W]; stable while `req[i]`=1
- `gnt`  output  N_REQ  one-hot, one-cycle pulse: byte of requester i accepted
- `tx_load`  output  1  one-cycle strobe to the transmitter: load `tx_data`
- `tx_data`  output  DATA_W  byte presented to the transmitter; registered
- `tx_busy`  input  1  transmitter is sending a frame
- `tx_done`  input  1  one-cycle pulse at end of stop bit
- `owner`  output  clog2(N_REQ)  index of the current/last granted requester
- `active`  output  1  high while in LOAD, WAIT or SEND

## Operation
- One clock domain. All outputs are registered.
- Reset values: `gnt`=0, `tx_load`=0, `tx_data`=0, `owner`=0, `active`=0, state IDLE, priority pointer `ptr`=N_REQ-1 (requester 0 wins first).
- States: IDLE, LOAD, WAIT, SEND.
- IDLE: if `req`≠0, select the first set bit searching `ptr+1, ptr+2, …` modulo N_REQ. Register `owner`, `tx_data`=selected byte, `ptr`=selected index, then go to LOAD. If `req`=0, stay in IDLE.
- LOAD (exactly 1 cycle): `gnt[owner]`=1, `tx_load`=1. Then go to WAIT.
- WAIT: go to SEND when `tx_busy`=1. If `tx_done`=1, go to IDLE; `tx_done` takes precedence over `tx_busy`.
- SEND: on `tx_done`=1, go to IDLE (or see Configuration). `tx_busy` falling without `tx_done` also ends the frame, and the block goes to IDLE.
- Changes to `req` or `req_data` after `gnt` have no effect on the byte in flight. A requester keeping `req` high is treated as having a new byte and re-arbitrates.
- `req` arriving while non-IDLE is held off until the next IDLE arbitration. There is no queueing.
- Reset mid-operation: return immediately to the reset values. The in-flight byte is abandoned.

## Timing
- `req` high in IDLE at cycle T gives `gnt`/`tx_load` high during cycle T+1.
- Minimum spacing between grants: LOAD + 1 cycle in WAIT/SEND + 1 cycle in IDLE.
- `tx_done` at cycle T leaves the block in IDLE at T+1. The next grant is no earlier than T+2.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,…,N_REQ-1,0. No requester waits more than N_REQ-1 frames.

## Configuration
- `UART_TX_ARB_BURST_EN` defined:
  - In SEND, on `tx_done`, if `req[owner]`=1 and the burst count is below BURST_MAX-1, go directly to LOAD with the same owner. `tx_data` is recaptured from that owner's slice, the burst count is incremented, and `ptr` is unchanged.
  - Otherwise go to IDLE. The burst count clears on entering IDLE and on reset.
  - Under this rule one requester receives at most BURST_MAX consecutive grants.
- `UART_TX_ARB_BURST_EN` not defined: every frame returns through IDLE and rotates priority. `BURST_MAX` and the burst counter are absent.

## Test plan
- Reset with `req`=4'b1111 held, then release reset: the first `gnt`=4'b0001 with `tx_data`=req_data[7:0]. `active`=0 and `tx_load`=0 while `rst`=1.
- `req`=4'b1111 continuous, transmitter model gives `tx_busy` 2 cycles after load and `tx_done` 10 cycles later: `gnt` sequence is 0001, 0010, 0100, 1000, 0001. Each grant is a single cycle coincident with `tx_load`.
- Only `req[2]`=1 with byte 0xA5: `tx_load` the cycle after the request, `tx_data`=0xA5, `owner`=2. `active` drops the cycle after `tx_done`.
- Assert `rst` while in SEND: all outputs return to their reset values asynchronously. After release, requester 0 has priority again.
- `tx_done` asserted in WAIT before `tx_busy`: the block goes to IDLE and the next grant follows arbitration normally.
- `UART_TX_ARB_BURST_EN` with BURST_MAX=4 and `req`=4'b0011 continuous: requester 0 receives 4 consecutive grants without IDLE cycles, then requester 1 receives 4.
